// File: rtl/cycle_timer_pkg.sv
// Shared types for the programmable cycle timer: count mode and run state.
package cycle_timer_pkg;

  typedef enum logic [1:0] {
    CT_WRAP     = 2'd0,
    CT_SATURATE = 2'd1,
    CT_ONESHOT  = 2'd2,
    CT_RSVD     = 2'd3
  } ct_mode_e;

  typedef enum logic {
    CT_IDLE = 1'b0,
    CT_RUN  = 1'b1
  } ct_state_e;

endpackage

// File: rtl/cycle_timer_prescaler.sv
// Step divider for cycle_timer: one step_en per prescale+1 advancing cycles.
// Only built when CYCLE_TIMER_PRESCALE_EN is defined.
`ifdef CYCLE_TIMER_PRESCALE_EN
module cycle_timer_prescaler #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         adv,
  input  logic [W-1:0] prescale,
  output logic         step_en
);

  logic [W-1:0] cnt_q;

  // Clearing re-arms a full period, so the first step after start/load
  // lands prescale+1 advancing cycles later.
  assign step_en = adv && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst)                 cnt_q <= '0;
    else if (clr || step_en) cnt_q <= prescale;
    else if (adv)            cnt_q <= cnt_q - W'(1);
  end

endmodule
`endif

// File: rtl/cycle_timer.sv
// Programmable up/down cycle timer with wrap/saturate/one-shot modes and tc pulse.
// Optional step prescaler enabled by defining CYCLE_TIMER_PRESCALE_EN.
module cycle_timer
  import cycle_timer_pkg::*;
#(
  parameter int WIDTH = 16
`ifdef CYCLE_TIMER_PRESCALE_EN
  , parameter int PRESCALE_W = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             start,
  input  logic             stop,
  input  logic             load_en,
  input  logic [WIDTH-1:0] i,
  input  logic [WIDTH-1:0] limit,
  input  logic [1:0]       mode,
  input  logic             dir,
`ifdef CYCLE_TIMER_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] prescale,
`endif
  output logic [WIDTH-1:0] o,
  output logic             tc,
  output logic             running,
  output logic             done
);

  ct_state_e        state_q, state_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;

  ct_mode_e         mode_e;
  logic [WIDTH-1:0] origin, terminal, o_step;
  logic             step_en, step;

  assign mode_e   = ct_mode_e'(mode);
  assign origin   = dir ? limit : '0;
  assign terminal = dir ? '0 : limit;
  assign o_step   = dir ? (o_q - WIDTH'(1)) : (o_q + WIDTH'(1));

`ifdef CYCLE_TIMER_PRESCALE_EN
  cycle_timer_prescaler #(.W(PRESCALE_W)) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .clr      (load_en | stop | start),
    .adv      ((state_q == CT_RUN) && clk_en),
    .prescale (prescale),
    .step_en  (step_en)
  );
`else
  assign step_en = 1'b1;
`endif

  assign step = (state_q == CT_RUN) && clk_en && step_en;

  always_comb begin
    state_d = state_q;
    o_d     = o_q;
    tc_d    = 1'b0;
    done_d  = done_q;
    if (load_en) begin
      o_d    = (i > limit) ? limit : i;
      done_d = 1'b0;
    end else if (stop) begin
      state_d = CT_IDLE;
    end else if (start) begin
      state_d = CT_RUN;
      o_d     = origin;
      done_d  = 1'b0;
    end else if (step) begin
      if (o_q > limit) begin
        // limit shrank under the count: resync silently
        o_d = origin;
      end else if (o_q == terminal) begin
        if (mode_e == CT_ONESHOT) begin
          state_d = CT_IDLE;
          done_d  = 1'b1;
          tc_d    = 1'b1;
        end else if (mode_e != CT_SATURATE) begin
          o_d  = origin;
          tc_d = (origin == terminal);
        end
      end else begin
        o_d  = o_step;
        tc_d = (o_step == terminal);
        // one-shot finishes on arrival so done/idle line up with the final tc
        if ((mode_e == CT_ONESHOT) && (o_step == terminal)) begin
          state_d = CT_IDLE;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CT_IDLE;
      o_q     <= '0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      o_q     <= o_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
    end
  end

  assign o       = o_q;
  assign tc      = tc_q;
  assign running = (state_q == CT_RUN);
  assign done    = done_q;

endmodule

// File: tb/tb_cycle_timer.sv
// Directed self-checking bench for cycle_timer (WIDTH=4); prescaler section
// runs only when CYCLE_TIMER_PRESCALE_EN is defined.
module tb_cycle_timer;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst, clk_en, start, stop, load_en, dir;
  logic [WIDTH-1:0] i, limit;
  logic [1:0]       mode;
  logic [WIDTH-1:0] o;
  logic             tc, running, done;
`ifdef CYCLE_TIMER_PRESCALE_EN
  logic [7:0]       prescale;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cycle_timer #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .start    (start),
    .stop     (stop),
    .load_en  (load_en),
    .i        (i),
    .limit    (limit),
    .mode     (mode),
    .dir      (dir),
`ifdef CYCLE_TIMER_PRESCALE_EN
    .prescale (prescale),
`endif
    .o        (o),
    .tc       (tc),
    .running  (running),
    .done     (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk4(input string tag, input int eo, input bit etc, input bit erun, input bit edone);
    chk({tag, ".o"},       32'(o),       32'(eo));
    chk({tag, ".tc"},      32'(tc),      32'(etc));
    chk({tag, ".running"}, 32'(running), 32'(erun));
    chk({tag, ".done"},    32'(done),    32'(edone));
  endtask

  // advance one edge; outputs are sampled and inputs changed 1ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wrap_o [7]  = '{1, 2, 3, 4, 5, 0, 1};
    int sat_o  [10] = '{1, 1, 2, 2, 3, 3, 4, 4, 4, 4};
    bit sat_en [10] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 1};

    rst = 1'b1; start = 1'b1; stop = 1'b0; load_en = 1'b0; clk_en = 1'b1;
    i = '0; limit = 4'd5; mode = 2'd0; dir = 1'b0;
`ifdef CYCLE_TIMER_PRESCALE_EN
    prescale = 8'd0;
`endif
    #1;

    // reset held with start asserted
    for (int k = 0; k < 3; k++) begin
      tick();
      chk4("reset", 0, 0, 0, 0);
    end
    rst = 1'b0; start = 1'b0;
    tick();
    chk4("idle_after_reset", 0, 0, 0, 0);

    // WRAP up, limit=5
    start = 1'b1;
    tick();
    chk4("wrap_start", 0, 0, 1, 0);
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tick();
      chk4($sformatf("wrap_%0d", k), wrap_o[k], wrap_o[k] == 5, 1, 0);
    end

    // ONESHOT down, limit=3
    mode = 2'd2; dir = 1'b1; limit = 4'd3; start = 1'b1;
    tick();
    chk4("os_start", 3, 0, 1, 0);
    start = 1'b0;
    tick(); chk4("os_2", 2, 0, 1, 0);
    tick(); chk4("os_1", 1, 0, 1, 0);
    tick(); chk4("os_0", 0, 1, 0, 1);
    tick(); chk4("os_hold", 0, 0, 0, 1);
    start = 1'b1;
    tick();
    chk4("os_restart", 3, 0, 1, 0);
    start = 1'b0;

    // SATURATE up, limit=4, clk_en toggling
    mode = 2'd1; dir = 1'b0; limit = 4'd4; start = 1'b1;
    tick();
    chk4("sat_start", 0, 0, 1, 0);
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      clk_en = sat_en[k];
      tick();
      chk4($sformatf("sat_%0d", k), sat_o[k], k == 6, 1, 0);
    end
    load_en = 1'b1; i = 4'd9;
    tick();
    chk4("sat_load_clamp", 4, 0, 1, 0);
    load_en = 1'b0;

    // simultaneous events from RUN with o=2
    mode = 2'd0; limit = 4'd5; clk_en = 1'b0; load_en = 1'b1; i = 4'd2;
    tick();
    chk4("sim_setup", 2, 0, 1, 0);
    i = 4'd1; stop = 1'b1; start = 1'b1;
    tick();
    chk4("sim_load_wins", 1, 0, 1, 0);
    load_en = 1'b0;
    tick();
    chk4("sim_stop_wins", 1, 0, 0, 0);
    stop = 1'b0; start = 1'b0;

    // limit=0 WRAP: tc on every enabled step
    limit = 4'd0; clk_en = 1'b1; start = 1'b1;
    tick();
    chk4("lim0_start", 0, 0, 1, 0);
    start = 1'b0;
    tick(); chk4("lim0_a", 0, 1, 1, 0);
    tick(); chk4("lim0_b", 0, 1, 1, 0);
    clk_en = 1'b0;
    tick(); chk4("lim0_off", 0, 0, 1, 0);
    clk_en = 1'b1;
    tick(); chk4("lim0_c", 0, 1, 1, 0);

    // limit shrinks below the count mid-run
    limit = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk4("shrink_pre", 4, 0, 1, 0);
    limit = 4'd2;
    tick(); chk4("shrink_resync", 0, 0, 1, 0);
    tick(); chk4("shrink_1", 1, 0, 1, 0);
    tick(); chk4("shrink_2", 2, 1, 1, 0);
    tick(); chk4("shrink_wrap", 0, 0, 1, 0);

    // reset mid-run
    rst = 1'b1;
    tick(); chk4("rst_midrun", 0, 0, 0, 0);
    rst = 1'b0;
    tick(); chk4("rst_release", 0, 0, 0, 0);

`ifdef CYCLE_TIMER_PRESCALE_EN
    // prescale=2: one step per 3 cycles, tc every 9
    prescale = 8'd2; limit = 4'd2; mode = 2'd0; dir = 1'b0; start = 1'b1;
    tick();
    chk4("ps_start", 0, 0, 1, 0);
    start = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      tick();
      chk4($sformatf("ps_%0d", k), (k / 3) % 3, (k % 9) == 6, 1, 0);
    end
    tick();
    load_en = 1'b1; i = 4'd0;
    tick();
    chk4("ps_load", 0, 0, 1, 0);
    load_en = 1'b0;
    tick(); chk4("ps_load_a", 0, 0, 1, 0);
    tick(); chk4("ps_load_b", 0, 0, 1, 0);
    tick(); chk4("ps_load_c", 1, 0, 1, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cycle_timer.md
# cycle_timer

Parametrised programmable cycle counter/timer, the successor to the bench free-running counter and load counter. It adds a programmable terminal value, up/down direction, wrap/saturate/one-shot modes, a terminal-count pulse and a run/done state machine. It is used by benches as a cycle limiter and event timer, and by RTL as a frame/line interval timer.

## Interface

Parameters:
- WIDTH, 16, counter and limit bit width (≥2)
- PRESCALE_W, 8, prescaler width (present only with CYCLE_TIMER_PRESCALE_EN)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- clk_en  in  1  count enable; a step is taken only when high
- start  in  1  start/restart pulse
- stop  in  1  abort to IDLE
- load_en  in  1  load `i` into counter
- i  in  WIDTH  load value
- limit  in  WIDTH  terminal bound; count range is 0..limit
- mode  in  2  0 WRAP, 1 SATURATE, 2 ONESHOT, 3 reserved (behaves as WRAP)
- dir  in  1  0 up, 1 down
- prescale  in  PRESCALE_W  divider (present only with CYCLE_TIMER_PRESCALE_EN)
- o  out  WIDTH  current count
- tc  out  1  terminal-count pulse
- running  out  1  state is RUN
- done  out  1  one-shot completed, sticky

## Operation

- Reset is one clock, synchronous and active-high. While `rst` is high: state IDLE, o=0, tc=0, running=0, done=0. Reset mid-run aborts immediately.
- Origin and terminal:
  - up: origin 0, terminal `limit`
  - down: origin `limit`, terminal 0
- States: IDLE, RUN.
  - IDLE→RUN on `start`. The same edge sets o=origin and done=0.
  - RUN→IDLE on `stop` (o holds, done unchanged).
  - RUN→IDLE on the ONESHOT terminal step.
  - `start` in RUN restarts: o=origin, state stays RUN.
- Priority per edge: rst > load_en > stop > start > step.
- Load: o=`i`, clamped to `limit` if `i` > `limit`. Load is legal in either state, does not change state, clears done and clears the prescaler.
- Step: occurs only in RUN with clk_en=1 (and prescaler expired, if compiled in).
  - Non-terminal step: o±1.
  - Terminal step, taken when o==terminal:
    - WRAP: o=origin, stays RUN
    - SATURATE: o holds at terminal, stays RUN, further steps produce no change
    - ONESHOT: o holds at terminal, state goes to IDLE, done=1
- tc is registered. It is high for exactly one cycle, in the cycle after the edge on which o becomes equal to terminal through a step. A load to the terminal value does not pulse tc. SATURATE pulses once on arrival and never while holding.
- limit==0: o stays 0. Every step is terminal; in WRAP, tc pulses on every step.
- `limit` or `dir` changed mid-run: takes effect on the next step. If o is outside 0..limit, the next step sets o=origin with no tc.
- Arithmetic is unsigned WIDTH bits, and o never leaves 0..limit through a step.

## Timing

- `start` sampled at edge N: running=1 and o=origin after edge N. The first step is at edge N+1 if clk_en=1.
- Step latency: o updates on the edge where the step condition is true. tc is high in the following cycle, aligned with o==terminal.
- ONESHOT: running=0 and done=1 appear in the same cycle as the final tc.
- stop, load and start all take effect on the sampling edge. There are no combinational input-to-output paths.

## Configuration

- Macro CYCLE_TIMER_PRESCALE_EN.
- Defined: adds parameter PRESCALE_W and port `prescale`. A step is taken once every prescale+1 qualifying (RUN and clk_en) cycles. The prescaler is cleared by rst, start, load_en and stop. prescale=0 behaves as if the macro were undefined.
- Undefined: no prescale port and no prescaler logic; every qualifying cycle is a step.

## Structure

- Package `cycle_timer_pkg`: mode enum (`CT_WRAP`, `CT_SATURATE`, `CT_ONESHOT`, `CT_RSVD`) and state enum (`CT_IDLE`, `CT_RUN`).
- One sub-module, `cycle_timer_prescaler`: a down-counter with clear and load that emits a one-cycle `step_en`. It is instantiated only under CYCLE_TIMER_PRESCALE_EN.

## Test plan

- Reset held 3 cycles with start=1 → o=0, tc=0, running=0, done=0 throughout; IDLE after release.
- WIDTH=4, limit=5, up, WRAP, clk_en=1, start → o: 0,1,2,3,4,5,0,1…; tc high only in the cycles where o=5; running stays 1.
- limit=3, down, ONESHOT, start → o: 3,2,1,0 then holds at 0; tc, done=1 and running=0 in the same cycle; a later start restores o=3 and clears done.
- limit=4, up, SATURATE, clk_en toggling 1/0 → o advances only on enabled cycles and holds at 4; tc pulses once; a load of i=9 sets o=4 with no tc.
- Simultaneous events in RUN with o=2: load_en(i=1)+stop+start → o=1, state RUN, done=0. Next cycle stop+start → IDLE. limit=0 in WRAP → tc pulses on every enabled cycle.
- With CYCLE_TIMER_PRESCALE_EN, prescale=2, limit=2, up, WRAP → o increments every 3rd cycle; tc appears every 9 cycles; a mid-run load clears the prescaler phase.
